// File: rtl/tick_monitor.sv
// tick_monitor: receive-side checker for an active-low tick pulse.
// Measures the cycle distance between successive tick falling edges, flags
// periods outside ExpRatio +/- Tol, reports loss when no tick arrives within
// ExpRatio + Tol cycles, and declares lock after LockCount good periods.
//
// Output semantics: valid_o is a one-cycle strobe with no back-pressure;
// period_o is meaningful in the cycle valid_o is high and holds afterwards.
// err_o only ever pulses together with valid_o; lost_o never does.
module tick_monitor #(
   parameter int ExpRatio  = 5,
   parameter int Tol       = 0,
   parameter int LockCount = 3,
   parameter int CntWidth  = 16
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                enable_i,
   input  logic                tick_ni,
   output logic [CntWidth-1:0] period_o,
   output logic                valid_o,
   output logic                err_o,
   output logic                lost_o,
   output logic                locked_o,
   output logic [1:0]          dbg_state_o
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ARM     = 2'd1,
      S_MEASURE = 2'd2
   } state_t;

   localparam int GoodW = $clog2(LockCount + 1);
   localparam logic [CntWidth-1:0] MaxCnt  = CntWidth'(ExpRatio + Tol);
   localparam logic [CntWidth-1:0] MinCnt  = CntWidth'(ExpRatio - Tol);
   localparam logic [GoodW-1:0]    LockVal = GoodW'(LockCount);

   state_t              r_state;
   logic [CntWidth-1:0] r_cnt;
   logic [GoodW-1:0]    r_good;
   logic                r_tick_q;
   logic [CntWidth-1:0] r_period;
   logic                r_valid;
   logic                r_err;
   logic                r_lost;
   logic                r_locked;

   logic                w_edge;
   logic                w_in_tol;
   logic                w_timeout;
   logic [GoodW-1:0]    w_good_next;

   // A falling edge is a high sample last cycle followed by a low sample now.
   assign w_edge    = r_tick_q & ~tick_ni;
   assign w_in_tol  = (r_cnt >= MinCnt) && (r_cnt <= MaxCnt);
   assign w_timeout = (r_cnt == MaxCnt);

   // Tick history runs independently of enable so a low level present at
   // enable time is never mistaken for an edge.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_tick_q <= 1'b1;
      end else begin
         r_tick_q <= tick_ni;
      end
   end

   // Next value of the good-period run length; lock is derived from it so
   // locked_o drops in the same cycle err_o or lost_o rises.
   always_comb begin
      w_good_next = r_good;
      if (!enable_i) begin
         w_good_next = '0;
      end else if (r_state == S_MEASURE) begin
         if (w_edge) begin
            if (!w_in_tol) begin
               w_good_next = '0;
            end else if (r_good != LockVal) begin
               w_good_next = r_good + GoodW'(1);
            end
         end else if (w_timeout) begin
            w_good_next = '0;
         end
      end
   end

   // Measurement FSM with registered outputs; disable overrides everything.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_good   <= '0;
         r_period <= '0;
         r_valid  <= 1'b0;
         r_err    <= 1'b0;
         r_lost   <= 1'b0;
         r_locked <= 1'b0;
      end else begin
         r_valid  <= 1'b0;
         r_err    <= 1'b0;
         r_lost   <= 1'b0;
         r_good   <= w_good_next;
         r_locked <= (w_good_next == LockVal);
         if (!enable_i) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
         end else begin
            case (r_state)
               S_IDLE: begin
                  r_state <= S_ARM;
               end
               S_ARM: begin
                  if (w_edge) begin
                     r_state <= S_MEASURE;
                     r_cnt   <= CntWidth'(1);
                  end
               end
               S_MEASURE: begin
                  if (w_edge) begin
                     r_period <= r_cnt;
                     r_valid  <= 1'b1;
                     r_err    <= ~w_in_tol;
                     r_cnt    <= CntWidth'(1);
                  end else if (w_timeout) begin
                     r_lost  <= 1'b1;
                     r_state <= S_ARM;
                     r_cnt   <= '0;
                  end else begin
                     r_cnt <= r_cnt + CntWidth'(1);
                  end
               end
               default: begin
                  r_state <= S_IDLE;
                  r_cnt   <= '0;
               end
            endcase
         end
      end
   end

   assign period_o    = r_period;
   assign valid_o     = r_valid;
   assign err_o       = r_err;
   assign lost_o      = r_lost;
   assign locked_o    = r_locked;
   assign dbg_state_o = r_state;

endmodule

// File: tb/tb_tick_monitor.sv
// Bench for tick_monitor: two instances (Tol = 0 and Tol = 1) share one
// stimulus stream and are compared every cycle against an edge-timestamp model.
module tb_tick_monitor;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b0;
  logic tick_n = 1'b1;

  logic [15:0] period0, period1;
  logic valid0, valid1, err0, err1, lost0, lost1, locked0, locked1;
  logic [1:0] dbg0, dbg1;

  int checks = 0;
  int errors = 0;

  // clock / reset
  always #5 clk = ~clk;

  tick_monitor #(.ExpRatio(5), .Tol(0), .LockCount(3), .CntWidth(16)) u_dut0 (
    .clk_i(clk), .rst_i(rst), .enable_i(enable), .tick_ni(tick_n),
    .period_o(period0), .valid_o(valid0), .err_o(err0), .lost_o(lost0),
    .locked_o(locked0), .dbg_state_o(dbg0)
  );

  tick_monitor #(.ExpRatio(5), .Tol(1), .LockCount(3), .CntWidth(16)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .enable_i(enable), .tick_ni(tick_n),
    .period_o(period1), .valid_o(valid1), .err_o(err1), .lost_o(lost1),
    .locked_o(locked1), .dbg_state_o(dbg1)
  );

  wire [19:0] obs0 = {valid0, err0, lost0, locked0, period0};
  wire [19:0] obs1 = {valid1, err1, lost1, locked1, period1};

  // reference model: timestamps of falling edges, distances in cycles
  int m_tol[2] = '{0, 1};
  int m_exp = 5;
  int m_lock = 3;
  int m_t;
  bit m_prev;
  bit m_active;
  bit m_ref[2];
  int m_last[2];
  int m_good[2];
  int m_per[2];
  logic [19:0] m_out[2];

  task automatic model_reset();
    m_t = 0;
    m_prev = 1'b1;
    m_active = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m_ref[i] = 1'b0;
      m_last[i] = 0;
      m_good[i] = 0;
      m_per[i] = 0;
      m_out[i] = '0;
    end
  endtask

  task automatic model_step(input bit en, input bit tk);
    bit edge_seen;
    edge_seen = m_prev && !tk;
    m_prev = tk;
    m_t++;
    for (int i = 0; i < 2; i++) begin
      bit v, e, l;
      int p, d;
      v = 0; e = 0; l = 0;
      if (!en) begin
        m_ref[i] = 0;
        m_good[i] = 0;
      end else if (m_active) begin
        if (edge_seen) begin
          if (m_ref[i]) begin
            p = m_t - m_last[i];
            d = (p > m_exp) ? p - m_exp : m_exp - p;
            v = 1;
            m_per[i] = p;
            if (d <= m_tol[i]) begin
              if (m_good[i] < m_lock) m_good[i]++;
            end else begin
              e = 1;
              m_good[i] = 0;
            end
          end
          m_ref[i] = 1;
          m_last[i] = m_t;
        end else if (m_ref[i] && (m_t - m_last[i] == m_exp + m_tol[i])) begin
          l = 1;
          m_ref[i] = 0;
          m_good[i] = 0;
        end
      end
      p = m_per[i];
      m_out[i] = {v, e, l, (m_good[i] == m_lock), p[15:0]};
    end
    m_active = en;
  endtask

  // driver tasks
  bit st_en[$];
  bit st_tk[$];

  task automatic stim_clear();
    st_en.delete();
    st_tk.delete();
  endtask

  task automatic add_hold(input bit en, input bit tk, input int n);
    for (int i = 0; i < n; i++) begin
      st_en.push_back(en);
      st_tk.push_back(tk);
    end
  endtask

  // one low of width w, then highs up to a total of p cycles
  task automatic add_period(input bit en, input int p, input int w);
    add_hold(en, 1'b0, w);
    add_hold(en, 1'b1, p - w);
  endtask

  task automatic step_cycle(input bit en, input bit tk);
    enable = en;
    tick_n = tk;
    @(posedge clk);
    model_step(en, tk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    enable = 1'b0;
    tick_n = 1'b1;
    repeat (2) @(posedge clk);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // scenarios
  task automatic test_reset();
    apply_reset();
    checks++;
    if (obs0 !== 20'd0 || dbg0 !== 2'd0) begin
      errors++;
      $display("FAIL reset dut0 got=%h/%0d exp=0/0", obs0, dbg0);
    end
    checks++;
    if (obs1 !== 20'd0 || dbg1 !== 2'd0) begin
      errors++;
      $display("FAIL reset dut1 got=%h/%0d exp=0/0", obs1, dbg1);
    end
  endtask

  task automatic test_nominal_lock();
    stim_clear();
    add_hold(1, 1, 2);
    repeat (7) add_period(1, 5, 1);
    for (int i = 0; i < st_en.size(); i++) begin
      step_cycle(st_en[i], st_tk[i]);
      checks++;
      if (obs0 !== m_out[0]) begin
        errors++;
        $display("FAIL nominal dut0 i=%0d got=%h exp=%h", i, obs0, m_out[0]);
      end
      checks++;
      if (obs1 !== m_out[1]) begin
        errors++;
        $display("FAIL nominal dut1 i=%0d got=%h exp=%h", i, obs1, m_out[1]);
      end
    end
    checks++;
    if (locked0 !== 1'b1 || period0 !== 16'd5) begin
      errors++;
      $display("FAIL nominal_final got locked=%b period=%0d exp locked=1 period=5", locked0, period0);
    end
  endtask

  task automatic test_short_long();
    stim_clear();
    add_period(1, 4, 1);
    add_period(1, 6, 1);
    repeat (5) add_period(1, 5, 1);
    for (int i = 0; i < st_en.size(); i++) begin
      step_cycle(st_en[i], st_tk[i]);
      checks++;
      if (obs0 !== m_out[0]) begin
        errors++;
        $display("FAIL short_long dut0 i=%0d got=%h exp=%h", i, obs0, m_out[0]);
      end
      checks++;
      if (obs1 !== m_out[1]) begin
        errors++;
        $display("FAIL short_long dut1 i=%0d got=%h exp=%h", i, obs1, m_out[1]);
      end
    end
  endtask

  task automatic test_tolerance();
    stim_clear();
    repeat (3) add_period(1, 5, 1);
    add_period(1, 4, 1);
    add_period(1, 6, 1);
    add_period(1, 5, 1);
    add_period(1, 3, 1);
    repeat (3) add_period(1, 5, 1);
    add_period(1, 6, 2);
    add_period(1, 2, 1);
    add_period(1, 5, 1);
    for (int i = 0; i < st_en.size(); i++) begin
      step_cycle(st_en[i], st_tk[i]);
      checks++;
      if (obs0 !== m_out[0]) begin
        errors++;
        $display("FAIL tolerance dut0 i=%0d got=%h exp=%h", i, obs0, m_out[0]);
      end
      checks++;
      if (obs1 !== m_out[1]) begin
        errors++;
        $display("FAIL tolerance dut1 i=%0d got=%h exp=%h", i, obs1, m_out[1]);
      end
    end
  endtask

  task automatic test_disable();
    int mark_a, mark_b;
    logic [15:0] saved;
    stim_clear();
    repeat (5) add_period(1, 5, 1);
    add_hold(1, 0, 1);
    add_hold(1, 1, 1);
    mark_a = st_en.size();
    add_hold(0, 0, 3);
    add_hold(1, 0, 8);
    mark_b = st_en.size();
    add_hold(1, 1, 2);
    repeat (5) add_period(1, 5, 1);
    saved = '0;
    for (int i = 0; i < st_en.size(); i++) begin
      step_cycle(st_en[i], st_tk[i]);
      checks++;
      if (obs0 !== m_out[0]) begin
        errors++;
        $display("FAIL disable dut0 i=%0d got=%h exp=%h", i, obs0, m_out[0]);
      end
      checks++;
      if (obs1 !== m_out[1]) begin
        errors++;
        $display("FAIL disable dut1 i=%0d got=%h exp=%h", i, obs1, m_out[1]);
      end
      if (i == mark_a - 1) saved = 16'd5;
      if (i == mark_b - 1) begin
        checks++;
        if (locked0 !== 1'b0 || period0 !== saved || valid0 !== 1'b0) begin
          errors++;
          $display("FAIL disable_hold got locked=%b period=%0d valid=%b exp 0/%0d/0", locked0, period0, valid0, saved);
        end
      end
    end
  endtask

  task automatic test_stuck_low();
    int mark, nlost0, nlost1;
    stim_clear();
    repeat (5) add_period(1, 5, 1);
    mark = st_en.size();
    add_hold(1, 0, 25);
    nlost0 = 0;
    nlost1 = 0;
    for (int i = 0; i < st_en.size(); i++) begin
      step_cycle(st_en[i], st_tk[i]);
      checks++;
      if (obs0 !== m_out[0]) begin
        errors++;
        $display("FAIL stuck dut0 i=%0d got=%h exp=%h", i, obs0, m_out[0]);
      end
      checks++;
      if (obs1 !== m_out[1]) begin
        errors++;
        $display("FAIL stuck dut1 i=%0d got=%h exp=%h", i, obs1, m_out[1]);
      end
      if (i >= mark) begin
        nlost0 += lost0;
        nlost1 += lost1;
      end
    end
    checks++;
    if (nlost0 != 1 || nlost1 != 1) begin
      errors++;
      $display("FAIL stuck_count got=%0d/%0d exp=1/1", nlost0, nlost1);
    end
  endtask

  task automatic test_random();
    int p, w;
    stim_clear();
    for (int s = 0; s < 300; s++) begin
      if ($urandom_range(0, 19) == 0) begin
        add_hold(0, 1'($urandom_range(0, 1)), $urandom_range(1, 3));
      end else begin
        p = $urandom_range(2, 8);
        w = (p > 2 && $urandom_range(0, 3) == 0) ? 2 : 1;
        add_period(1, p, w);
      end
    end
    for (int i = 0; i < st_en.size(); i++) begin
      step_cycle(st_en[i], st_tk[i]);
      checks++;
      if (obs0 !== m_out[0]) begin
        errors++;
        $display("FAIL random dut0 i=%0d got=%h exp=%h", i, obs0, m_out[0]);
      end
      checks++;
      if (obs1 !== m_out[1]) begin
        errors++;
        $display("FAIL random dut1 i=%0d got=%h exp=%h", i, obs1, m_out[1]);
      end
    end
  endtask

  task automatic test_reset_mid();
    stim_clear();
    add_hold(1, 1, 2);
    repeat (5) add_period(1, 5, 1);
    add_hold(1, 0, 1);
    add_hold(1, 1, 2);
    for (int i = 0; i < st_en.size(); i++) begin
      step_cycle(st_en[i], st_tk[i]);
    end
    checks++;
    if (locked0 !== 1'b1 || locked1 !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_prelock got=%b/%b exp=1/1", locked0, locked1);
    end
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if (obs0 !== 20'd0 || obs1 !== 20'd0) begin
      errors++;
      $display("FAIL reset_mid_async got=%h/%h exp=0/0", obs0, obs1);
    end
    model_reset();
    @(posedge clk);
    #2;
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step_cycle(1'b0, 1'(i % 3 == 0 ? 0 : 1));
      checks++;
      if (obs0 !== m_out[0] || obs1 !== m_out[1] || obs0 !== 20'd0) begin
        errors++;
        $display("FAIL reset_mid_idle i=%0d got=%h/%h exp=%h/%h", i, obs0, obs1, m_out[0], m_out[1]);
      end
    end
  endtask

  // sequence and final report
  initial begin
    model_reset();
    test_reset();
    test_nominal_lock();
    test_short_long();
    test_tolerance();
    test_disable();
    test_stuck_low();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
